// File: rtl/keypad_emu_pkg.sv
// Shared types and helpers for the keypad emulator: FSM state encoding and key-code field extraction.
package keypad_emu_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        READY,
        HOLD,
        GAP
    } state_e;

    function automatic logic [1:0] key_row(input logic [KEY_W-1:0] code);
        return code[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [KEY_W-1:0] code);
        return code[1:0];
    endfunction

endpackage

// File: rtl/keypad_emu_matrix.sv
// Registered column-to-row response of the emulated key, including contact bounce
// when KEYPAD_BOUNCE_EN is defined.
module keypad_emu_matrix
    import keypad_emu_pkg::*;
`ifdef KEYPAD_BOUNCE_EN
#(
    parameter int BOUNCE_CYCLES = 256
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    input  state_e           state_d_i,
    input  logic [KEY_W-1:0] code_d_i,
    input  logic [COLS-1:0]  col_i,
`ifdef KEYPAD_BOUNCE_EN
    input  logic [31:0]      elapsed_i,
`endif
    output logic [ROWS-1:0]  row_o
);

    logic            contact;
    logic [ROWS-1:0] row_d;
    logic [ROWS-1:0] row_q;

    always_comb begin
        contact = (state_d_i == SETTLE) || (state_d_i == READY) || (state_d_i == HOLD);
`ifdef KEYPAD_BOUNCE_EN
        // Chatter with period 8 while inside the bounce window of SETTLE or GAP.
        if (elapsed_i < 32'(BOUNCE_CYCLES)) begin
            if (state_d_i == SETTLE) contact = ~elapsed_i[2];
            if (state_d_i == GAP)    contact =  elapsed_i[2];
        end
`endif
        for (int r = 0; r < ROWS; r++) begin
            row_d[r] = ~(contact && (key_row(code_d_i) == 2'(r)) && !col_i[key_col(code_d_i)]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) row_q <= '1;
        else       row_q <= row_d;
    end

    assign row_o = row_q;

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 keypad responder: press-sequence FSM with dwell counters driving an emulated key and dat_ready.
// Optional contact bounce is enabled by defining KEYPAD_BOUNCE_EN.
module keypad_emulator
    import keypad_emu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 5400,
    parameter int READY_CYCLES  = 5400,
    parameter int HOLD_CYCLES   = 5400,
    parameter int GAP_CYCLES    = 5400,
    parameter int BOUNCE_CYCLES = 256
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [COLS-1:0]  col_i,
    input  logic [KEY_W-1:0] key_code_i,
    input  logic             press_req_i,
    output logic             req_ready_o,
    output logic [ROWS-1:0]  row_o,
    output logic             dat_ready_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int MAX_AB = (SETTLE_CYCLES > READY_CYCLES) ? SETTLE_CYCLES : READY_CYCLES;
    localparam int MAX_CD = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    if (SETTLE_CYCLES < 1 || READY_CYCLES < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1
        || BOUNCE_CYCLES < 0) begin : g_bad_params
        $error("keypad_emulator: dwell parameters must be >= 1");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic             dat_ready_q, done_q;

    // Each state counts down from its dwell length minus one and leaves on zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (press_req_i) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    code_d  = key_code_i;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = READY;
                    cnt_d   = CNT_W'(READY_CYCLES - 1);
                end else cnt_d = cnt_q - 1'b1;
            end
            READY: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                end else cnt_d = cnt_q - 1'b1;
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                end else cnt_d = cnt_q - 1'b1;
            end
            GAP: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            code_q      <= '0;
            dat_ready_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            dat_ready_q <= (state_d == READY);
            done_q      <= (state_q == GAP) && (cnt_q == '0);
        end
    end

`ifdef KEYPAD_BOUNCE_EN
    logic [31:0] elapsed_d;
    int          len_d;

    // Cycles already spent in the upcoming state, recovered from the down-counter.
    always_comb begin
        len_d = 1;
        unique case (state_d)
            SETTLE:  len_d = SETTLE_CYCLES;
            READY:   len_d = READY_CYCLES;
            HOLD:    len_d = HOLD_CYCLES;
            GAP:     len_d = GAP_CYCLES;
            default: len_d = 1;
        endcase
        elapsed_d = 32'(len_d - 1) - 32'(cnt_d);
    end

    keypad_emu_matrix #(
        .BOUNCE_CYCLES(BOUNCE_CYCLES)
    ) u_matrix (
        .clk       (clk),
        .reset     (reset),
        .state_d_i (state_d),
        .code_d_i  (code_d),
        .col_i     (col_i),
        .elapsed_i (elapsed_d),
        .row_o     (row_o)
    );
`else
    keypad_emu_matrix u_matrix (
        .clk       (clk),
        .reset     (reset),
        .state_d_i (state_d),
        .code_d_i  (code_d),
        .col_i     (col_i),
        .row_o     (row_o)
    );
`endif

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign dat_ready_o = dat_ready_q;
    assign done_o      = done_q;

endmodule
